x9dn_voter_seq: RTL and testbench



---
 rtl/x9dn_voter_seq.sv | 148 ++++++++++++++
 tb/tb_x9dn_voter_seq.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/x9dn_voter_seq.sv
// Two-stage replicated-vote classifier with a run-length persistence filter.
// S1 captures the vote sample; S2 classifies it and holds the registered decision.
module x9dn_voter_seq #(
    parameter int CH   = 6,
    parameter int HOLD = 3,
    parameter int CW   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CH-1:0] in_vote,
    input  logic [1:0]    in_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1:0]    out_dec,
    output logic [CW-1:0] out_cnt,
    output logic          out_tie
);

    localparam int PW = $clog2(CH + 1);
    localparam logic [PW-1:0] LP_CH   = PW'(CH);
    localparam logic [PW:0]   LP_CH2  = (PW + 1)'(CH);
    localparam logic [CW-1:0] LP_HOLD = CW'(HOLD);

    localparam logic [1:0] C_NONE = 2'b00;
    localparam logic [1:0] C_HIGH = 2'b01;
    localparam logic [1:0] C_LOW  = 2'b10;
    localparam logic [1:0] C_CONF = 2'b11;

    // Handshake: a transfer happens on a rising edge where valid & ready are both
    // high and rst is low; a producer holds its payload stable while valid & ~ready.
    logic          r_s1_valid;
    logic [CH-1:0] r_s1_vote;
    logic [1:0]    r_s1_mode;

    logic          r_out_valid;
    logic [1:0]    r_out_dec;
    logic [CW-1:0] r_cnt;
    logic          r_out_tie;
    logic [1:0]    r_prev_class;
    logic [1:0]    r_prev_mode;

    logic          w_s2_free;
    logic          w_adv;
    logic          w_acc;
    logic [PW-1:0] w_pop;
    logic [PW:0]   w_pop2;
    logic [1:0]    w_class;
    logic          w_tie;
    logic          w_same;
    logic [CW-1:0] w_cnt_nxt;
    logic [1:0]    w_dec_nxt;

    assign w_s2_free = ~r_out_valid | out_ready;
    assign w_adv     = r_s1_valid & w_s2_free;
    assign in_ready  = ~rst & (~r_s1_valid | w_s2_free);
    assign w_acc     = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_vote  <= '0;
            r_s1_mode  <= 2'b00;
        end else if (w_acc) begin
            r_s1_valid <= 1'b1;
            r_s1_vote  <= in_vote;
            r_s1_mode  <= in_mode;
        end else if (w_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < CH; i++) begin
            w_pop = w_pop + PW'(r_s1_vote[i]);
        end
    end

    assign w_pop2 = {w_pop, 1'b0};

    always_comb begin
        w_class = C_CONF;
        w_tie   = 1'b0;
        case (r_s1_mode)
            2'b01: begin
                if (w_pop2 > LP_CH2) begin
                    w_class = C_HIGH;
                end else if (w_pop2 < LP_CH2) begin
                    w_class = C_LOW;
                end else begin
                    w_class = C_CONF;
                    w_tie   = 1'b1;
                end
            end
            2'b10: begin
                w_class = (w_pop != '0) ? C_HIGH : C_LOW;
            end
            default: begin
                if (w_pop == LP_CH) begin
                    w_class = C_HIGH;
                end else if (w_pop == '0) begin
                    w_class = C_LOW;
                end else begin
                    w_class = C_CONF;
                end
            end
        endcase
    end

    // A zero counter marks "no run yet", so the first sample after reset always starts at 1.
    assign w_same = (w_class == r_prev_class) && (r_s1_mode == r_prev_mode) && (r_cnt != '0);

    always_comb begin
        w_cnt_nxt = CW'(1);
        if (w_same) begin
            w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
        end
        w_dec_nxt = (w_cnt_nxt >= LP_HOLD) ? w_class : C_NONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_dec    <= C_NONE;
            r_cnt        <= '0;
            r_out_tie    <= 1'b0;
            r_prev_class <= C_NONE;
            r_prev_mode  <= 2'b00;
        end else if (w_adv) begin
            r_out_valid  <= 1'b1;
            r_out_dec    <= w_dec_nxt;
            r_cnt        <= w_cnt_nxt;
            r_out_tie    <= w_tie;
            r_prev_class <= w_class;
            r_prev_mode  <= r_s1_mode;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_dec   = r_out_dec;
    assign out_cnt   = r_cnt;
    assign out_tie   = r_out_tie;

endmodule

// File: tb/tb_x9dn_voter_seq.sv
// Scoreboard bench for x9dn_voter_seq: a reference model predicts each result
// at input acceptance; a negedge monitor pops and compares on output handshakes.
module tb_x9dn_voter_seq;

    localparam int CH = 6;
    localparam int HOLD = 3;
    localparam int CW = 4;
    localparam int EW = 2 + CW + 1;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [CH-1:0] in_vote;
    logic [1:0]    in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_dec;
    logic [CW-1:0] out_cnt;
    logic          out_tie;

    x9dn_voter_seq #(.CH(CH), .HOLD(HOLD), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_vote(in_vote), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_dec(out_dec), .out_cnt(out_cnt), .out_tie(out_tie)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_out = 0;
    logic [EW-1:0] exp_q[$];
    logic [1:0]    last_dec;
    logic [CW-1:0] last_cnt;
    logic          last_tie;
    logic          rand_rdy = 1'b0;

    // reference model state
    logic [1:0]    m_prev_class;
    logic [1:0]    m_prev_mode;
    int            m_cnt;

    task automatic model_clear();
        m_prev_class = 2'b00;
        m_prev_mode  = 2'b00;
        m_cnt        = 0;
    endtask

    task automatic push_exp(input logic [CH-1:0] v, input logic [1:0] m);
        int p;
        logic [1:0] cls;
        logic tie;
        logic [1:0] dec;
        p = $countones(v);
        tie = 1'b0;
        if (m == 2'b01) begin
            if (2 * p > CH) cls = 2'b01;
            else if (2 * p < CH) cls = 2'b10;
            else begin cls = 2'b11; tie = 1'b1; end
        end else if (m == 2'b10) begin
            cls = (p != 0) ? 2'b01 : 2'b10;
        end else begin
            if (p == CH) cls = 2'b01;
            else if (p == 0) cls = 2'b10;
            else cls = 2'b11;
        end
        if (cls == m_prev_class && m == m_prev_mode && m_cnt != 0)
            m_cnt = (m_cnt >= 15) ? 15 : m_cnt + 1;
        else
            m_cnt = 1;
        m_prev_class = cls;
        m_prev_mode = m;
        dec = (m_cnt >= HOLD) ? cls : 2'b00;
        exp_q.push_back({dec, CW'(m_cnt), tie});
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            logic [EW-1:0] obs;
            logic [EW-1:0] e;
            obs = {out_dec, out_cnt, out_tie};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output got=%h expected=none", obs);
            end else begin
                e = exp_q.pop_front();
                if (obs !== e) begin
                    bad++;
                    $display("FAIL scoreboard got dec=%b cnt=%0d tie=%b expected dec=%b cnt=%0d tie=%b",
                             out_dec, out_cnt, out_tie, e[EW-1:EW-2], e[CW:1], e[0]);
                end
            end
            last_dec = out_dec;
            last_cnt = out_cnt;
            last_tie = out_tie;
            n_out++;
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    // All driver tasks start and end at posedge+1.
    task automatic send(input logic [CH-1:0] v, input logic [1:0] m);
        int g;
        in_vote = v;
        in_mode = m;
        in_valid = 1'b1;
        g = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) begin
                push_exp(v, m);
                @(posedge clk); #1;
                break;
            end
            g++;
            if (g > 200) begin
                total++; bad++;
                $display("FAIL send_timeout got in_ready=0 expected 1 within 200 cycles");
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        int g;
        in_valid = 1'b0;
        out_ready = 1'b1;
        g = 0;
        while (g < 100 && (exp_q.size() != 0 || out_valid)) begin
            @(negedge clk);
            g++;
        end
        total++;
        if (g >= 100) begin
            bad++;
            $display("FAIL drain_timeout got pending=%0d expected 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic check_last(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b expected=0", out_valid); end
        total++; if (out_dec !== 2'b00) begin bad++; $display("FAIL reset_out_dec got=%b expected=00", out_dec); end
        total++; if (out_cnt !== '0) begin bad++; $display("FAIL reset_out_cnt got=%0d expected=0", out_cnt); end
        total++; if (out_tie !== 1'b0) begin bad++; $display("FAIL reset_out_tie got=%b expected=0", out_tie); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b expected=0", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        send(6'h3F, 2'b00);
        in_valid = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_early got out_valid=%b expected=0", out_valid); end
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL latency_two got out_valid=%b expected=1", out_valid); end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) send(6'h3F, 2'b00);
        drain();
        check_last("stream_cnt", int'(last_cnt), 4);
        check_last("stream_dec", int'(last_dec), 1);
    endtask

    task automatic test_class_change();
        for (int i = 0; i < 3; i++) send(6'h00, 2'b00);
        drain();
        check_last("low_dec", int'(last_dec), 2);
        check_last("low_cnt", int'(last_cnt), 3);
        send(6'h15, 2'b00);
        drain();
        check_last("conflict_cnt", int'(last_cnt), 1);
        check_last("conflict_dec", int'(last_dec), 0);
    endtask

    task automatic test_majority();
        send(6'h07, 2'b01);
        drain();
        check_last("tie_flag", int'(last_tie), 1);
        for (int i = 0; i < 3; i++) send(6'h0F, 2'b01);
        drain();
        check_last("maj_dec", int'(last_dec), 1);
        check_last("maj_tie", int'(last_tie), 0);
        send(6'h01, 2'b01);
        drain();
        check_last("maj_low_cnt", int'(last_cnt), 1);
    endtask

    task automatic test_idle_gap();
        send(6'h3F, 2'b10);
        send(6'h3F, 2'b10);
        drain();
        repeat (4) @(posedge clk);
        #1;
        send(6'h3F, 2'b10);
        drain();
        check_last("idle_keeps_cnt", int'(last_cnt), 3);
    endtask

    task automatic test_backpressure();
        logic [CH-1:0] bp_v[4];
        logic [EW+1-1:0] snap;
        int acc;
        int base;
        bp_v[0] = 6'h0F; bp_v[1] = 6'h1F; bp_v[2] = 6'h3E; bp_v[3] = 6'h01;
        out_ready = 1'b0;
        acc = 0;
        base = n_out;
        for (int c = 0; c < 6; c++) begin
            in_vote = bp_v[acc % 4];
            in_mode = 2'b01;
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) begin
                push_exp(bp_v[acc % 4], 2'b01);
                acc++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_last("bp_accepts", acc, 2);
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b expected=0", in_ready); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid got=%b expected=1", out_valid); end
        snap = {out_valid, out_dec, out_cnt, out_tie};
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if ({out_valid, out_dec, out_cnt, out_tie} !== snap) begin
                bad++;
                $display("FAIL bp_stable got=%h expected=%h", {out_valid, out_dec, out_cnt, out_tie}, snap);
            end
        end
        @(posedge clk); #1;
        drain();
        check_last("bp_drained", n_out - base, 2);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) send(6'h01, 2'b10);
        drain();
        check_last("sat_cnt", int'(last_cnt), 15);
        check_last("sat_dec", int'(last_dec), 1);
        send(6'h01, 2'b00);
        drain();
        check_last("mode_change_cnt", int'(last_cnt), 1);
        check_last("mode_change_dec", int'(last_dec), 0);
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        send(6'h3F, 2'b00);
        send(6'h3F, 2'b00);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b expected=0", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        model_clear();
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b expected=0", out_valid); end
        @(posedge clk); #1;
        send(6'h3F, 2'b00);
        drain();
        check_last("post_rst_cnt", int'(last_cnt), 1);
    endtask

    task automatic test_random();
        logic [CH-1:0] pool[5];
        logic [CH-1:0] v;
        pool[0] = 6'h00; pool[1] = 6'h3F; pool[2] = 6'h07; pool[3] = 6'h0F; pool[4] = 6'h01;
        rand_rdy = 1'b1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) v = CH'($urandom_range(0, 63));
            else v = pool[$urandom_range(0, 4)];
            send(v, 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 5) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        rand_rdy = 1'b0;
        @(posedge clk); #2;
        drain();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_vote = '0;
        in_mode = 2'b00;
        out_ready = 1'b0;
        last_dec = '0;
        last_cnt = '0;
        last_tie = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_class_change();
        test_majority();
        test_idle_gap();
        test_backpressure();
        test_saturation();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1);
    end

endmodule
